// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared encodings and defaults for the instruction store loader
// Contents: loader FSM state codes, geometry defaults, the word served when the CPU must not execute.
package imem_loader_pkg;

  localparam int DEPTH_DEF       = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/imem_loader_sync_rise.sv
// rtl/imem_loader_sync_rise.sv - multi-flop synchroniser with rising-edge detector
// Ports: clk, rst (async active-high), d (asynchronous input),
//        level (synchronised level), rise (one-cycle pulse on a synchronised 0->1).
module sync_rise #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - writable instruction store with byte-serial program loader
// Ports: clk, rst (async active-high); load_req, byte_strobe, byte_in (asynchronous pins);
//        fetch_addr -> instruction (combinational fetch); cpu_hold, load_done, load_err,
//        word_count (loader status).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_strobe,
  input  logic [7:0]        byte_in,
  input  logic [15:0]       fetch_addr,
  output logic [15:0]       instruction,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [14:0]       DEPTH_W15 = 15'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [7:0]        hi_reg;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       mem [DEPTH];

  logic req_level, req_rise;
  logic strobe_rise, strobe_level_unused;
  logic mem_we;
  logic fetch_addr_lsb_unused;

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (load_req),
    .level (req_level),
    .rise  (req_rise)
  );

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (byte_strobe),
    .level (strobe_level_unused),
    .rise  (strobe_rise)
  );

  // Abort (load_req dropped) wins over a same-cycle strobe, so the write is gated on req_level.
  assign mem_we = (state == ST_WAIT_LO) && req_level && strobe_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      hi_reg     <= 8'h00;
      ptr        <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (req_rise) begin
            state      <= ST_WAIT_HI;
            ptr        <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
          end
        end
        ST_WAIT_HI: begin
          if (!req_level) begin
            state    <= ST_RUN;
            load_err <= 1'b1;
          end else if (strobe_rise) begin
            hi_reg <= byte_in;
            state  <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!req_level) begin
            state    <= ST_RUN;
            load_err <= 1'b1;
          end else if (strobe_rise) begin
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
            state      <= (ptr == LAST_PTR) ? ST_FINISH : ST_WAIT_HI;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Storage has no reset: a reset mid-load keeps whatever words were already written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= {hi_reg, byte_in};
  end

  assign cpu_hold  = (state != ST_RUN);
  assign load_done = (state == ST_FINISH);

  assign fetch_addr_lsb_unused = fetch_addr[0];

  always_comb begin
    instruction = NOP_WORD;
    if (!cpu_hold && (fetch_addr[15:1] < DEPTH_W15))
      instruction = mem[fetch_addr[ADDR_W:1]];
  end

endmodule
